// File: rtl/icache_pkg.sv
// Shared types and sizing for the direct-mapped instruction cache.
// A line holds two 32-bit words; the tag field is sized for the widest
// tag any legal configuration needs (AW up to 32, LINES at least 2).
package icache_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } state_t;

    // Sizing of the default configuration (LINES=16, AW=32).
    localparam int DEF_LINES = 16;
    localparam int DEF_AW    = 32;
    localparam int IDX_W     = $clog2(DEF_LINES);
    localparam int TAG_W     = DEF_AW - 3 - IDX_W;

    // Widest possible tag: AW=32 with only two lines.
    localparam int MAX_TAG_W = 28;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [31:0]          w0;
        logic [31:0]          w1;
    } line_t;

    // Index width for a given line count.
    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    // Tag width for a given address width and line count.
    function automatic int tag_width(input int aw, input int lines);
        return aw - 3 - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Flop-based line storage: asynchronous read, one write port, and a
// bulk clear of the valid bits. Tags and data carry no reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IW    = idx_width(LINES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [IW-1:0] rd_idx,
    output line_t         rd_line,
    input  logic          we,
    input  logic [IW-1:0] wr_idx,
    input  line_t         wr_line
);

    logic [LINES-1:0]     valid;
    logic [MAX_TAG_W-1:0] tags [LINES];
    logic [31:0]          w0s  [LINES];
    logic [31:0]          w1s  [LINES];

    // Valid bits: a clear wins over a same-cycle write so a flush landing on the fill cycle leaves the line invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= wr_line.valid;
        end
    end

    // Tag and data storage, written only on the fill cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx] <= wr_line.tag;
            w0s[wr_idx]  <= wr_line.w0;
            w1s[wr_idx]  <= wr_line.w1;
        end
    end

    // Asynchronous read of the indexed line.
    always_comb begin
        rd_line       = '0;
        rd_line.valid = valid[rd_idx];
        rd_line.tag   = tags[rd_idx];
        rd_line.w0    = w0s[rd_idx];
        rd_line.w1    = w1s[rd_idx];
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache. Hits are served combinationally; a miss
// stalls fetch while two word requests refill the 64-bit line over the
// memory instrreq/abort handshake. Also counts misses (saturating).
module icache
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    input  logic          fetch_en,
    input  logic          flush,
    output logic [31:0]   instr,
    output logic          hit,
    output logic          stall,
    output logic [31:0]   mem_instradr,
    output logic          mem_instrreq,
    input  logic          mem_abort,
    input  logic [31:0]   mem_instr,
    output logic [31:0]   miss_cnt
);

    localparam int IW = idx_width(LINES);
    localparam int TW = tag_width(AW, LINES);

    state_t        state;
    logic [AW-4:0] fill_line;
    logic          word_sel;
    logic          flush_pending;
    logic [31:0]   wbuf0;
    logic [31:0]   wbuf1;
    logic [31:0]   instr_last;

    logic [IW-1:0] pc_idx;
    logic [TW-1:0] pc_tag;
    logic [1:0]    pc_unused;
    line_t         rd_line;
    line_t         wr_line;
    logic          tag_match;
    logic          miss;
    logic [31:0]   rd_word;
    logic [AW-1:0] adr_full;

    assign pc_idx    = pc[3 +: IW];
    assign pc_tag    = pc[AW-1 -: TW];
    assign pc_unused = pc[1:0];

    icache_array #(
        .LINES (LINES),
        .IW    (IW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .rd_idx  (pc_idx),
        .rd_line (rd_line),
        .we      (state == FILL),
        .wr_idx  (fill_line[IW-1:0]),
        .wr_line (wr_line)
    );

    // Lookup: hits only count in RUN; outside a hit instr shows the last word read.
    always_comb begin
        tag_match = rd_line.valid && (rd_line.tag == MAX_TAG_W'(pc_tag));
        hit       = (state == RUN) && fetch_en && tag_match;
        stall     = fetch_en && !hit;
        miss      = (state == RUN) && fetch_en && !tag_match && !flush;
        rd_word   = pc[2] ? rd_line.w1 : rd_line.w0;
        instr     = hit ? rd_word : instr_last;
    end

    // Memory request and the line being assembled for the fill write.
    always_comb begin
        adr_full      = {fill_line, word_sel, 2'b00};
        mem_instradr  = 32'(adr_full);
        mem_instrreq  = (state == REQ);
        wr_line       = '0;
        wr_line.valid = !flush_pending;
        wr_line.tag   = MAX_TAG_W'(fill_line[AW-4 -: TW]);
        wr_line.w0    = wbuf0;
        wr_line.w1    = wbuf1;
    end

    // Refill sequencer, latched line address and saturating miss counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            fill_line     <= '0;
            word_sel      <= 1'b0;
            flush_pending <= 1'b0;
            miss_cnt      <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (miss) begin
                        fill_line <= pc[AW-1:3];
                        word_sel  <= 1'b0;
                        if (miss_cnt != '1) begin
                            miss_cnt <= miss_cnt + 32'd1;
                        end
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (!mem_abort) begin
                        if (!word_sel) begin
                            word_sel <= 1'b1;
                            state    <= REQ;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    flush_pending <= 1'b0;
                    state         <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Word buffers capture returned data the first cycle memory drops abort.
    always_ff @(posedge clk) begin
        if ((state == WAIT) && !mem_abort) begin
            if (word_sel) begin
                wbuf1 <= mem_instr;
            end else begin
                wbuf0 <= mem_instr;
            end
        end
    end

    // Remember the last word served so instr holds steady while not hitting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_last <= '0;
        end else if (hit) begin
            instr_last <= rd_word;
        end
    end

endmodule
